eda_regional_max_scan: RTL and testbench
========================================

# eda_regional_max_scan

Parametrised successor of `eda_regional_max`. It holds one M×N image in an internal single-port synchronous RAM. On `start` it scans every pixel in row-major order and tests it against its 4- or 8-connected neighbourhood. It streams one local-maximum mask bit per pixel over a valid/ready handshake. It sits between the pixel loader and the downstream mask buffer in the regional-max datapath.

## Interface
Parameters:
- `M`, 6: image rows (≥1).
- `N`, 6: image columns (≥1).
- `PIXEL_WIDTH`, 8: unsigned pixel width.
- `CONN`, 8: neighbourhood connectivity, 4 or 8; any other value is a compile-time error.
- `ADDR_WIDTH`, `$clog2(M*N)` (min 1): linear address width.

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `clear`, in, 1: synchronous abort to IDLE. RAM contents are kept.
- `write_en`, in, 1: pixel write strobe.
- `wr_addr`, in, ADDR_WIDTH: linear address, row-major, `i*N + j`.
- `pixel_in`, in, PIXEL_WIDTH: pixel data.
- `start`, in, 1: begin scan. Sampled only in IDLE.
- `strict`, in, 1: 1 = strict (`>`) mode, 0 = non-strict (`>=`) mode. Latched at `start`.
- `busy`, out, 1: high in SCAN and EMIT.
- `done`, out, 1: one-cycle pulse after the last mask bit is accepted.
- `mask_valid`, out, 1: mask bit available.
- `mask_ready`, in, 1: downstream accepts the mask bit.
- `mask_addr`, out, ADDR_WIDTH: linear address of the pixel the bit belongs to.
- `mask_bit`, out, 1: 1 = pixel is a local maximum.

## Operation
- **States:** IDLE, SCAN, EMIT, DONE.
- **Reset / clear:** any state → IDLE. All outputs 0, counters 0. RAM is not reset. `clear` outranks every other input, `reset_n` outranks `clear`.
- **IDLE:**
  - `write_en` with `wr_addr < M*N` writes `pixel_in` to RAM.
  - Writes with out-of-range addresses are dropped.
  - `start` latches `strict`, sets the centre to (0,0) and goes to SCAN.
  - If `write_en` and `start` arrive in the same cycle, the write completes first and the scan sees the new value.
- **In SCAN, EMIT or DONE:** `write_en` and `start` are ignored.
- **SCAN, per centre (i,j):** step counter k runs 0..CONN+1.
  - Read issue, k ≤ CONN: k=0 reads the centre; k≥1 reads neighbour offset k.
  - CONN=8 neighbour order: (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
  - CONN=4 neighbour order: (-1,0), (0,-1), (0,+1), (+1,0).
  - Out-of-image neighbours are not read and are excluded from the test. They still occupy their cycle, so per-pixel timing is fixed.
  - Compare, k ≥ 1: read data from step k-1 is compared. The centre value is registered at k=1.
  - Running flag starts at 1 and is cleared when a valid neighbour is ≥ centre (strict mode) or > centre (non-strict mode).
  - At k=CONN+1: final compare, register `mask_bit` and `mask_addr`, go to EMIT.
- **EMIT:**
  - `mask_valid`=1. `mask_bit` and `mask_addr` are held stable until `mask_valid && mask_ready`.
  - On handshake with the last pixel (`M*N-1`): go to DONE.
  - On handshake otherwise: advance j, wrapping to the next i at `j=N-1`, and return to SCAN with k=0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Arithmetic:** unsigned compares only. Neighbour coordinates are computed with one extra sign bit and bounds-checked against 0..M-1 and 0..N-1.
- **Degenerate cases:**
  - M=N=1: the single pixel has no neighbours, so `mask_bit`=1 in both modes.
  - Flat image: all 1 in non-strict mode, all 0 in strict mode.

## Timing
- Read latency is 1 cycle; data for a read issued at k is compared at k+1.
- `mask_valid` rises CONN+2 cycles after SCAN is entered for a pixel.
- With `mask_ready` held at 1, each pixel takes CONN+3 cycles: 11 for CONN=8, 7 for CONN=4.
- Total scan time is `M*N*(CONN+3)` cycles plus 1 cycle for DONE.
- `busy` rises the cycle after `start` is sampled. It falls in the cycle DONE is entered, the same cycle `done` is 1.
- `mask_ready` low stalls EMIT indefinitely; no data is lost or changed.
- Reset values: `busy`, `done`, `mask_valid`, `mask_bit` and `mask_addr` are all 0.
- `clear` or `reset_n` asserted mid-scan: outputs are 0 the following cycle, no `done` pulse is issued, and a new `start` rescans from pixel 0.

## Test plan
- **Single peak, 8-connected:** 6×6, CONN=8, all pixels 0x10 except (2,3)=0x80, strict=1 → exactly one `mask_bit`=1, at `mask_addr`=15. `done` comes 36·11+1 cycles after `busy` rises.
- **Plateau modes:** flat 6×6 of 0x40 → 36 ones with strict=0 and 36 zeros with strict=1. `mask_addr` runs 0..35 in order.
- **Connectivity difference:** 3×3, centre 0x50, corners 0x60, edge midpoints 0x10, strict=1 → CONN=4 centre bit=1; CONN=8 centre bit=0.
- **Backpressure:** `mask_ready` toggled 1-0-0-1 per cycle → every pixel emitted exactly once, and `mask_bit`/`mask_addr` stay stable during stalls.
- **Abort and rejected inputs:**
  - `clear` during pixel 10 → outputs 0 next cycle, no `done`. A restart then yields the full 36 bits.
  - `write_en` while busy does not change RAM.
  - `wr_addr`=40 is dropped.
- **Degenerate image:** M=N=1, pixel 0x00, either mode → one bit = 1. `mask_valid` rises CONN+2 cycles after SCAN entry, followed by `done`.

Source files
------------

// File: rtl/eda_regional_max_scan.sv
// eda_regional_max_scan: scans an M x N image held in a single-port RAM and streams a
// local-maximum mask bit per pixel (4- or 8-connected) over valid/ready.
module eda_regional_max_scan #(
    parameter int M = 6,
    parameter int N = 6,
    parameter int PIXEL_WIDTH = 8,
    parameter int CONN = 8,
    parameter int ADDR_WIDTH = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   write_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   start,
    input  logic                   strict,
    output logic                   busy,
    output logic                   done,
    output logic                   mask_valid,
    input  logic                   mask_ready,
    output logic [ADDR_WIDTH-1:0]  mask_addr,
    output logic                   mask_bit
);
    localparam int PIX = M * N;
    localparam int RW = $clog2(M + 1);
    localparam int CW = $clog2(N + 1);
    localparam int KW = $clog2(CONN + 2);
    localparam logic [KW-1:0] K_LAST = KW'(CONN + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PIX - 1);
    // {di,dj} per step k, two's complement 2-bit each; entry 0 is the centre
    localparam logic [39:0] T8 = {4'b0000, 4'b0101, 4'b0100, 4'b0111, 4'b0001,
                                  4'b0011, 4'b1101, 4'b1100, 4'b1111, 4'b0000};
    localparam logic [39:0] T4 = {20'b0, 4'b0100, 4'b0001, 4'b0011, 4'b1100, 4'b0000};
    localparam logic [39:0] TAB = (CONN == 8) ? T8 : T4;

    generate
        if (CONN != 4 && CONN != 8) begin : g_bad_conn
            $error("eda_regional_max_scan: CONN must be 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_FIN} state_t;

    state_t state, state_nx;
    logic [PIXEL_WIDTH-1:0] ram [PIX];
    logic [PIXEL_WIDTH-1:0] rdata, centre;
    logic [KW-1:0] k;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [ADDR_WIDTH-1:0] pix, rd_addr, ram_addr;
    logic signed [1:0] di, dj;
    logic signed [RW:0] ni;
    logic signed [CW:0] nj;
    logic strict_q, flag, nb_ok, in_img, beaten, flag_nx, kill;

    assign kill = !reset_n || clear;
    assign {di, dj} = TAB[{k, 2'b00} +: 4];
    assign ni = $signed({1'b0, row}) + (RW + 1)'(di);
    assign nj = $signed({1'b0, col}) + (CW + 1)'(dj);
    assign in_img = !ni[RW] && ni < (RW + 1)'(M) && !nj[CW] && nj < (CW + 1)'(N);
    assign rd_addr = ADDR_WIDTH'(ni[RW-1:0]) * ADDR_WIDTH'(N) + ADDR_WIDTH'(nj[CW-1:0]);
    assign ram_addr = (state == S_IDLE) ? wr_addr : rd_addr;
    // nb_ok qualifies the data returning this cycle as an in-image neighbour
    assign beaten = nb_ok && (strict_q ? rdata >= centre : rdata > centre);
    assign flag_nx = flag && !beaten;
    assign busy = state == S_SCAN || state == S_EMIT;
    assign done = state == S_FIN;
    assign mask_valid = state == S_EMIT;

    always_ff @(posedge clk) begin
        if (!kill && state == S_IDLE && write_en && {1'b0, wr_addr} < (ADDR_WIDTH + 1)'(PIX))
            ram[wr_addr] <= pixel_in;
        rdata <= ram[ram_addr];
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_SCAN : S_IDLE;
            S_SCAN:  state_nx = (k == K_LAST) ? S_EMIT : S_SCAN;
            S_EMIT:  state_nx = !mask_ready ? S_EMIT : (pix == LAST) ? S_FIN : S_SCAN;
            default: state_nx = S_IDLE;
        endcase
        if (kill) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        state <= state_nx;
        if (kill) begin
            k         <= '0;
            row       <= '0;
            col       <= '0;
            pix       <= '0;
            strict_q  <= 1'b0;
            flag      <= 1'b0;
            nb_ok     <= 1'b0;
            centre    <= '0;
            mask_bit  <= 1'b0;
            mask_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    strict_q <= strict;
                    k        <= '0;
                    row      <= '0;
                    col      <= '0;
                    pix      <= '0;
                end
                S_SCAN: begin
                    k     <= (k == K_LAST) ? '0 : k + 1'b1;
                    nb_ok <= k != '0 && in_img;
                    flag  <= (k == '0) ? 1'b1 : flag_nx;
                    if (k == KW'(1)) centre <= rdata;
                    if (k == K_LAST) begin
                        mask_bit  <= flag_nx;
                        mask_addr <= pix;
                    end
                end
                S_EMIT: if (mask_ready && pix != LAST) begin
                    pix <= pix + 1'b1;
                    col <= (col == COL_LAST) ? '0 : col + 1'b1;
                    row <= (col == COL_LAST) ? row + 1'b1 : row;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_eda_regional_max_scan.sv
// tb_eda_regional_max_scan: directed checks of the regional-max scanner on 6x6, 3x3 and 1x1 images.
module tb_eda_regional_max_scan;
    logic clk = 0;
    always #5 clk = ~clk;

    logic reset_n = 0, clear = 0, write_en = 0, start = 0, strict = 0, mask_ready = 1;
    logic [5:0] wr_addr = 0;
    logic [7:0] pixel_in = 0;
    logic busy, done, mask_valid, mask_bit;
    logic [5:0] mask_addr;

    logic s_we = 0, t_we = 0, s_start = 0, s_strict = 0;
    logic [3:0] s_addr = 0;
    logic [7:0] s_pix = 0;
    logic a_busy, a_done, a_mv, a_bit, b_busy, b_done, b_mv, b_bit, c_busy, c_done, c_mv, c_bit;
    logic [3:0] a_addr, b_addr;
    logic c_addr;

    eda_regional_max_scan #(.M(6), .N(6), .PIXEL_WIDTH(8), .CONN(8)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .write_en(write_en), .wr_addr(wr_addr),
        .pixel_in(pixel_in), .start(start), .strict(strict), .busy(busy), .done(done),
        .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_addr(mask_addr), .mask_bit(mask_bit));

    eda_regional_max_scan #(.M(3), .N(3), .PIXEL_WIDTH(8), .CONN(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .write_en(s_we), .wr_addr(s_addr),
        .pixel_in(s_pix), .start(s_start), .strict(s_strict), .busy(a_busy), .done(a_done),
        .mask_valid(a_mv), .mask_ready(1'b1), .mask_addr(a_addr), .mask_bit(a_bit));

    eda_regional_max_scan #(.M(3), .N(3), .PIXEL_WIDTH(8), .CONN(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .write_en(s_we), .wr_addr(s_addr),
        .pixel_in(s_pix), .start(s_start), .strict(s_strict), .busy(b_busy), .done(b_done),
        .mask_valid(b_mv), .mask_ready(1'b1), .mask_addr(b_addr), .mask_bit(b_bit));

    eda_regional_max_scan #(.M(1), .N(1), .PIXEL_WIDTH(8), .CONN(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .write_en(t_we), .wr_addr(s_addr[0]),
        .pixel_in(s_pix), .start(s_start), .strict(s_strict), .busy(c_busy), .done(c_done),
        .mask_valid(c_mv), .mask_ready(1'b1), .mask_addr(c_addr), .mask_bit(c_bit));

    int checks = 0, errors = 0;
    logic mb [36];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0, a_dn = 0, b_dn = 0, c_dn = 0, c_ones = 0, c_t0 = 0, c_lat = 0, c_mt = 0, c_dt = 0;
    logic a_bits [16];
    logic b_bits [16];
    logic c_busy_q = 0, c_mv_q = 0;

    always @(negedge clk) begin
        cyc++;
        if (a_mv) a_bits[a_addr] = a_bit;
        if (b_mv) b_bits[b_addr] = b_bit;
        if (a_done) a_dn++;
        if (b_done) b_dn++;
        if (c_done) begin
            c_dn++;
            c_dt = cyc;
        end
        if (c_mv && c_bit) c_ones++;
        if (c_busy && !c_busy_q) c_t0 = cyc;
        if (c_mv && !c_mv_q) begin
            c_lat = cyc - c_t0;
            c_mt = cyc;
        end
        c_busy_q = c_busy;
        c_mv_q = c_mv;
    end

    task automatic load(input int peak_addr, input logic [7:0] peak, input logic [7:0] base);
        for (int a = 0; a < 36; a++) begin
            @(negedge clk);
            write_en = 1;
            wr_addr = 6'(a);
            pixel_in = (a == peak_addr) ? peak : base;
        end
        @(negedge clk);
        write_en = 0;
    endtask

    task automatic run_scan(input logic s, input logic bp, input logic wbusy,
                            output int n_hs, output int n_ones, output int n_cyc);
        int c;
        logic pv, pr, pb;
        logic [5:0] pa;
        @(negedge clk);
        start = 1;
        strict = s;
        @(negedge clk);
        start = 0;
        check("busy_rise", busy, 1);
        n_hs = 0; n_ones = 0; n_cyc = 0; pv = 0; pr = 1; pb = 0; pa = 0; c = 0;
        while (!done && c < 3000) begin
            n_cyc++;
            if (pv && !pr) begin
                check("stall_valid", mask_valid, 1);
                check("stall_bit", mask_bit, pb);
                check("stall_addr", mask_addr, pa);
            end
            mask_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            if (wbusy) begin
                write_en = (c == 5);
                wr_addr = 6'd14;
                pixel_in = 8'hff;
            end
            if (mask_valid && mask_ready) begin
                check("addr_order", mask_addr, n_hs);
                if (n_hs < 36) mb[n_hs] = mask_bit;
                n_ones += int'(mask_bit);
                n_hs++;
            end
            pv = mask_valid; pr = mask_ready; pb = mask_bit; pa = mask_addr;
            c++;
            @(negedge clk);
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        n_cyc++;
        mask_ready = 1;
        write_en = 0;
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    task automatic small_run(input logic s);
        int a0, b0, c0, o0, w;
        a0 = a_dn; b0 = b_dn; c0 = c_dn; o0 = c_ones;
        @(negedge clk);
        s_start = 1;
        s_strict = s;
        @(negedge clk);
        s_start = 0;
        w = 0;
        while ((a_dn == a0 || b_dn == b0 || c_dn == c0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("small_done", a_dn > a0 && b_dn > b0 && c_dn > c0, 1);
        check("one_px_bit", c_ones - o0, 1);
    endtask

    int hs, ones, ncyc, w, dcnt;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", mask_valid, 0);
        check("rst_bit", mask_bit, 0);
        check("rst_addr", mask_addr, 0);
        reset_n = 1;

        load(15, 8'h80, 8'h10);
        @(negedge clk);
        write_en = 1; wr_addr = 6'd40; pixel_in = 8'hff;
        @(negedge clk);
        write_en = 0;
        run_scan(1, 0, 0, hs, ones, ncyc);
        check("peak_hs", hs, 36);
        check("peak_ones", ones, 1);
        check("peak_bit15", mb[15], 1);
        check("peak_cycles", ncyc, 36 * 11 + 1);

        run_scan(0, 1, 0, hs, ones, ncyc);
        check("bp_hs", hs, 36);
        check("bp_ones", ones, 28);
        check("bp_bit15", mb[15], 1);
        check("bp_bit14", mb[14], 0);
        check("bp_bit0", mb[0], 1);

        load(0, 8'h40, 8'h40);
        run_scan(0, 0, 1, hs, ones, ncyc);
        check("flat_ns_hs", hs, 36);
        check("flat_ns_ones", ones, 36);
        run_scan(1, 0, 0, hs, ones, ncyc);
        check("flat_s_ones", ones, 0);

        @(negedge clk);
        start = 1; strict = 0;
        @(negedge clk);
        start = 0;
        w = 0;
        while (!(mask_valid && mask_addr == 6'd9) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("reach_px9", mask_addr, 9);
        repeat (3) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check("clr_busy", busy, 0);
        check("clr_valid", mask_valid, 0);
        check("clr_bit", mask_bit, 0);
        check("clr_addr", mask_addr, 0);
        check("clr_done", done, 0);
        dcnt = 0;
        repeat (450) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("no_done_after_clr", dcnt, 0);
        run_scan(0, 0, 0, hs, ones, ncyc);
        check("restart_hs", hs, 36);
        check("restart_ones", ones, 36);

        for (int a = 0; a < 9; a++) begin
            @(negedge clk);
            s_we = 1;
            s_addr = 4'(a);
            s_pix = (a == 4) ? 8'h50 : (a % 2 == 0) ? 8'h60 : 8'h10;
        end
        @(negedge clk);
        s_we = 0; t_we = 1; s_addr = 0; s_pix = 0;
        @(negedge clk);
        t_we = 0;
        small_run(1);
        check("c4_centre", a_bits[4], 1);
        check("c8_centre", b_bits[4], 0);
        check("c4_corner", a_bits[0], 1);
        check("c8_corner", b_bits[0], 1);
        check("c8_edge", b_bits[1], 0);
        check("one_px_latency", c_lat, 6);
        check("one_px_done_gap", c_dt - c_mt, 1);
        small_run(0);
        check("c4_centre_ns", a_bits[4], 1);
        check("c8_centre_ns", b_bits[4], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
